// File: rtl/pixel_stream_ctrl_pkg.sv
// Shared definitions for the pixel stream sequencer: FSM state encoding and
// the default address/length width.
package pixel_stream_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pixel_stream_ctrl_addr_counter.sv
// Loadable, wrapping address counter used for both the read and write-back
// address streams. Load takes priority over increment.
module addr_counter
  import pixel_stream_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Pixel run sequencer: one read per cycle, write-back one cycle later, operand
// mux select held for the run, and a one-cycle done pulse. All outputs registered.
module pixel_stream_ctrl
  import pixel_stream_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              use_imm,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              select_pixel1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] remaining;
  logic              use_imm_q;
  logic              launch;
  logic              rd_load, wr_load;
  logic [ADDR_W-1:0] rd_load_val, wr_load_val;
  logic              busy_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start) next_state = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)                           next_state = ST_IDLE;
        else if (remaining == ADDR_W'(1))    next_state = ST_DRAIN;
      end
      ST_DRAIN: next_state = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase

    launch = (state == ST_IDLE) && (next_state == ST_RUN);
    busy_d = (next_state == ST_RUN) || (next_state == ST_DRAIN);

    // Counters hold the live address while streaming and park at zero otherwise.
    rd_load     = (state == ST_IDLE) || (next_state != ST_RUN);
    rd_load_val = launch ? base_addr : '0;
    wr_load     = (state == ST_IDLE) || (next_state == ST_IDLE) || (next_state == ST_DONE);
    wr_load_val = launch ? dst_addr : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      use_imm_q     <= 1'b0;
      rd_en         <= 1'b0;
      wr_en         <= 1'b0;
      busy          <= 1'b0;
      select_pixel1 <= 1'b0;
      done          <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && start) begin
        remaining <= length;
        use_imm_q <= use_imm;
      end else if (state == ST_RUN) begin
        remaining <= remaining - ADDR_W'(1);
      end
      rd_en <= (next_state == ST_RUN);
      // The write trails the read by one cycle; an abort kills it immediately.
      wr_en         <= rd_en && (next_state != ST_IDLE);
      busy          <= busy_d;
      select_pixel1 <= busy_d && ((state == ST_IDLE) ? use_imm : use_imm_q);
      done          <= (next_state == ST_DONE);
    end
  end

  addr_counter #(.ADDR_W(ADDR_W)) u_rd_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (rd_load_val),
    .inc      (1'b1),
    .count    (rd_addr)
  );

  addr_counter #(.ADDR_W(ADDR_W)) u_wr_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_load),
    .load_val (wr_load_val),
    .inc      (wr_en),
    .count    (wr_addr)
  );

endmodule
